// File: rtl/mmu_pkg.sv
// Shared Sv39 MMU types and constants: PTE layout, SATP mode, page-walk FSM states.
package mmu_pkg;

    localparam logic [3:0]  SATP_MODE_SV39 = 4'd8;
    localparam int unsigned PGOFF_W        = 12;
    localparam int unsigned VPN_W          = 9;
    localparam int unsigned PPN_W          = 44;

    typedef struct packed {
        logic [9:0]  reserved;
        logic [25:0] ppn2;
        logic [8:0]  ppn1;
        logic [8:0]  ppn0;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_t;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StCheck,
        StDone,
        StFault
    } walk_state_e;

    function automatic logic [PPN_W-1:0] pte_ppn(input pte_t p);
        return {p.ppn2, p.ppn1, p.ppn0};
    endfunction

endpackage

// File: rtl/sv39_pte_check.sv
// Combinational Sv39 PTE validation: classifies leaf vs pointer and flags page faults.
module sv39_pte_check
    import mmu_pkg::*;
(
    input  pte_t       pte,
    input  logic [1:0] level,
    input  logic       is_write,
    output logic       is_leaf,
    output logic       fault
);

    logic [PPN_W-1:0] ppn;
    logic             misaligned;
    logic             unused_bits;

    assign unused_bits = ^{pte.rsw, pte.g, pte.u};

    always_comb begin
        ppn        = pte_ppn(pte);
        is_leaf    = pte.r | pte.x;
        misaligned = 1'b0;
        case (level)
            2'd2:    misaligned = (ppn[2*VPN_W-1:0] != '0);
            2'd1:    misaligned = (ppn[VPN_W-1:0] != '0);
            default: misaligned = 1'b0;
        endcase

        fault = ~pte.v | (pte.w & ~pte.r) | (pte.reserved != '0);
        // A/D are never updated by hardware, so a clear bit is a fault.
        if (is_leaf) begin
            fault = fault | misaligned | ~pte.a | (is_write & ~pte.d);
        end else begin
            fault = fault | (level == 2'd0);
        end
    end

endmodule

// File: rtl/sv39_walker.sv
// Sv39 page-table walker: up to three PTE reads per TLB miss, returns a 4 KiB fill or a fault.
module sv39_walker
    import mmu_pkg::*;
#(
    parameter int unsigned PA_W      = 56,
    parameter int unsigned TLB_IDX_W = 7
) (
    input  logic                      phi2,
    input  logic                      rst,
    input  logic [63:0]               satp,
    input  logic                      walk_req,
    input  logic [38:0]               walk_vaddr,
    input  logic                      walk_is_write,
    output logic                      walk_busy,
    output logic                      walk_done,
    output logic                      walk_fault,
    output logic                      fill_valid,
    output logic [TLB_IDX_W-1:0]      fill_index,
    output logic [39-12-TLB_IDX_W-1:0] fill_tag,
    output logic [PPN_W-1:0]          fill_ppn,
    output logic [7:0]                fill_flags,
    output logic [1:0]                fill_level,
    output logic                      mem_read_rq,
    output logic [PA_W-1:0]           mem_addr,
    input  logic [63:0]               mem_data,
    input  logic                      mem_ready
);

    walk_state_e      state_q, state_d;
    logic [38:0]      vaddr_q;
    logic             is_write_q;
    logic [PPN_W-1:0] a_q;
    logic [1:0]       lvl_q;
    pte_t             pte_q;

    logic             is_leaf;
    logic             pte_fault;
    logic [VPN_W-1:0] vpn;
    logic [PPN_W-1:0] leaf_ppn;
    logic [PPN_W-1:0] ptr_ppn;
    logic             unused_bits;

    assign unused_bits = ^{satp[59:44], vaddr_q[PGOFF_W-1:0]};
    assign ptr_ppn     = pte_ppn(pte_q);

    sv39_pte_check u_pte_check (
        .pte      (pte_q),
        .level    (lvl_q),
        .is_write (is_write_q),
        .is_leaf  (is_leaf),
        .fault    (pte_fault)
    );

    always_comb begin
        vpn      = vaddr_q[PGOFF_W +: VPN_W];
        leaf_ppn = ptr_ppn;
        // Superpages are split into 4 KiB fills using the VPN bits below the leaf level.
        case (lvl_q)
            2'd2: begin
                vpn      = vaddr_q[PGOFF_W+2*VPN_W +: VPN_W];
                leaf_ppn = {ptr_ppn[PPN_W-1:2*VPN_W], vaddr_q[PGOFF_W +: 2*VPN_W]};
            end
            2'd1: begin
                vpn      = vaddr_q[PGOFF_W+VPN_W +: VPN_W];
                leaf_ppn = {ptr_ppn[PPN_W-1:VPN_W], vaddr_q[PGOFF_W +: VPN_W]};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (walk_req) begin
                    state_d = (satp[63:60] == SATP_MODE_SV39) ? StReq : StFault;
                end
            end
            StReq:   if (mem_ready) state_d = StCheck;
            StCheck: begin
                if (pte_fault)    state_d = StFault;
                else if (is_leaf) state_d = StDone;
                else              state_d = StReq;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge phi2) begin
        if (rst) begin
            state_q    <= StIdle;
            vaddr_q    <= '0;
            is_write_q <= 1'b0;
            a_q        <= '0;
            lvl_q      <= '0;
            pte_q      <= '0;
            fill_index <= '0;
            fill_tag   <= '0;
            fill_ppn   <= '0;
            fill_flags <= '0;
            fill_level <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (walk_req) begin
                        vaddr_q    <= walk_vaddr;
                        is_write_q <= walk_is_write;
                        a_q        <= satp[PPN_W-1:0];
                        lvl_q      <= 2'd2;
                    end
                end
                StReq: if (mem_ready) pte_q <= mem_data;
                StCheck: begin
                    if (!pte_fault && !is_leaf) begin
                        a_q   <= ptr_ppn;
                        lvl_q <= lvl_q - 2'd1;
                    end else if (!pte_fault) begin
                        fill_index <= vaddr_q[PGOFF_W +: TLB_IDX_W];
                        fill_tag   <= vaddr_q[38:PGOFF_W+TLB_IDX_W];
                        fill_ppn   <= leaf_ppn;
                        fill_flags <= pte_q[7:0];
                        fill_level <= lvl_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign walk_busy   = (state_q != StIdle);
    assign walk_done   = (state_q == StDone) | (state_q == StFault);
    assign walk_fault  = (state_q == StFault);
    assign fill_valid  = (state_q == StDone);
    assign mem_read_rq = (state_q == StReq);
    assign mem_addr    = (state_q == StReq) ? PA_W'({a_q, vpn, 3'b000}) : '0;

endmodule

// File: tb/tb_sv39_walker.sv
// Self-checking bench for sv39_walker: directed walks plus random page tables vs a reference walk.
module tb_sv39_walker;

    logic        phi2 = 1'b0;
    logic        rst;
    logic [63:0] satp;
    logic        walk_req;
    logic [38:0] walk_vaddr;
    logic        walk_is_write;
    logic        walk_busy, walk_done, walk_fault, fill_valid;
    logic [6:0]  fill_index;
    logic [19:0] fill_tag;
    logic [43:0] fill_ppn;
    logic [7:0]  fill_flags;
    logic [1:0]  fill_level;
    logic        mem_read_rq;
    logic [55:0] mem_addr;
    logic [63:0] mem_data;
    logic        mem_ready;

    always #5 phi2 = ~phi2;

    sv39_walker #(.PA_W(56), .TLB_IDX_W(7)) dut (
        .phi2          (phi2),
        .rst           (rst),
        .satp          (satp),
        .walk_req      (walk_req),
        .walk_vaddr    (walk_vaddr),
        .walk_is_write (walk_is_write),
        .walk_busy     (walk_busy),
        .walk_done     (walk_done),
        .walk_fault    (walk_fault),
        .fill_valid    (fill_valid),
        .fill_index    (fill_index),
        .fill_tag      (fill_tag),
        .fill_ppn      (fill_ppn),
        .fill_flags    (fill_flags),
        .fill_level    (fill_level),
        .mem_read_rq   (mem_read_rq),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .mem_ready     (mem_ready)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [63:0] mem [logic [55:0]];

    // Reference walk results
    logic        exp_fault;
    logic [43:0] exp_ppn;
    logic [1:0]  exp_level;
    logic [7:0]  exp_flags;
    logic [55:0] exp_addrs[$];
    int          last_reads;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_pte(input logic [43:0] ppn, input logic [7:0] flags);
        return {10'h0, ppn, 2'b00, flags};
    endfunction

    function automatic logic [55:0] pte_addr(input logic [43:0] a, input logic [38:0] va,
                                             input int lvl);
        logic [38:0] idx;
        idx = (va >> (12 + 9 * lvl)) & 39'h1ff;
        return {a, 12'h000} + 56'(idx << 3);
    endfunction

    function automatic logic [63:0] mem_rd(input logic [55:0] addr);
        return mem.exists(addr) ? mem[addr] : 64'h0;
    endfunction

    task automatic model_walk(input logic [63:0] s, input logic [38:0] va, input bit wr);
        logic [43:0] a, ppn, mask;
        logic [63:0] pte;
        logic [55:0] addr;
        exp_addrs.delete();
        exp_fault = 1'b1;
        exp_ppn   = '0;
        exp_level = '0;
        exp_flags = '0;
        if (s[63:60] != 4'd8) return;
        a = s[43:0];
        for (int lvl = 2; lvl >= 0; lvl--) begin
            addr = pte_addr(a, va, lvl);
            exp_addrs.push_back(addr);
            pte = mem_rd(addr);
            ppn = pte[53:10];
            if (!pte[0] || (pte[2] && !pte[1]) || pte[63:54] != 10'h0) return;
            if (pte[1] || pte[3]) begin
                mask = (44'd1 << (9 * lvl)) - 44'd1;
                if ((ppn & mask) != 44'h0 || !pte[6] || (wr && !pte[7])) return;
                exp_fault = 1'b0;
                exp_ppn   = (ppn & ~mask) | (44'(va >> 12) & mask);
                exp_level = 2'(lvl);
                exp_flags = pte[7:0];
                return;
            end
            a = ppn;
        end
    endtask

    task automatic run_walk(input logic [63:0] s, input logic [38:0] va, input bit wr,
                            input int max_wait, input string tag);
        int cyc = 0, nreads = 0, waited = 0, tot_wait = 0, cur_wait;
        bit got_done = 0;
        model_walk(s, va, wr);
        cur_wait = $urandom_range(0, max_wait);
        @(negedge phi2);
        satp          = s;
        walk_vaddr    = va;
        walk_is_write = wr;
        walk_req      = 1'b1;
        mem_ready     = 1'b0;
        @(posedge phi2);
        #1;
        walk_req = 1'b0;
        satp     = {$urandom, $urandom};
        while (cyc < 200 && !got_done) begin
            @(negedge phi2);
            cyc++;
            mem_ready = 1'b0;
            mem_data  = {$urandom, $urandom};
            if (walk_done) begin
                got_done = 1;
                check_eq({tag, " fault"}, 64'(walk_fault), 64'(exp_fault));
                check_eq({tag, " fill_valid"}, 64'(fill_valid), 64'(!exp_fault));
                check_eq({tag, " reads"}, 64'(nreads), 64'(exp_addrs.size()));
                check_eq({tag, " done_cycle"}, 64'(cyc), 64'(2 * exp_addrs.size() + 1 + tot_wait));
                if (!exp_fault) begin
                    check_eq({tag, " ppn"}, 64'(fill_ppn), 64'(exp_ppn));
                    check_eq({tag, " level"}, 64'(fill_level), 64'(exp_level));
                    check_eq({tag, " flags"}, 64'(fill_flags), 64'(exp_flags));
                    check_eq({tag, " index"}, 64'(fill_index), 64'(va[18:12]));
                    check_eq({tag, " tag"}, 64'(fill_tag), 64'(va[38:19]));
                end
            end else if (mem_read_rq) begin
                if (waited < cur_wait) begin
                    waited++;
                    tot_wait++;
                end else begin
                    check_eq({tag, " read_in_range"}, 64'(nreads < exp_addrs.size()), 64'd1);
                    if (nreads < exp_addrs.size())
                        check_eq({tag, " addr"}, 64'(mem_addr), 64'(exp_addrs[nreads]));
                    mem_data  = mem_rd(mem_addr);
                    mem_ready = 1'b1;
                    nreads++;
                    waited   = 0;
                    cur_wait = $urandom_range(0, max_wait);
                end
            end else if ($urandom_range(0, 3) == 0) begin
                mem_ready = 1'b1;
            end
        end
        check_eq({tag, " completed"}, 64'(got_done), 64'd1);
        last_reads = nreads;
        @(negedge phi2);
        mem_ready = 1'b0;
        check_eq({tag, " idle_after"}, 64'(walk_busy | walk_done), 64'd0);
        if (!exp_fault) check_eq({tag, " ppn_stable"}, 64'(fill_ppn), 64'(exp_ppn));
    endtask

    function automatic logic [63:0] rand_pte(input int l);
        int          k;
        logic [43:0] ppn;
        logic [7:0]  flags;
        k     = $urandom_range(0, 9);
        ppn   = 44'({$urandom, $urandom});
        flags = 8'($urandom);
        if (k < 4) begin
            flags = {flags[7:4], 4'b0001};
        end else if (k < 8) begin
            flags[1:0] = 2'b11;
            flags[6]   = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 3) != 0) ppn = ppn & ~((44'd1 << (9 * l)) - 44'd1);
        end else if (k == 9) begin
            return {10'($urandom | 1), ppn, 2'b00, flags | 8'h01};
        end
        return {10'h0, ppn, 2'($urandom), flags};
    endfunction

    localparam logic [43:0] Root = 44'h80000;

    initial begin
        logic [63:0] s;
        logic [38:0] va;
        logic [43:0] a;
        logic [63:0] p;

        rst           = 1'b1;
        satp          = '0;
        walk_req      = 1'b0;
        walk_vaddr    = '0;
        walk_is_write = 1'b0;
        mem_data      = '0;
        mem_ready     = 1'b0;
        repeat (3) @(negedge phi2);
        rst = 1'b0;
        check_eq("reset ctrl", 64'({walk_busy, walk_done, walk_fault, fill_valid, mem_read_rq}),
                 64'd0);
        check_eq("reset mem_addr", 64'(mem_addr), 64'd0);
        check_eq("reset fill", {fill_ppn, fill_flags, fill_level, fill_index, fill_tag[2:0]},
                 64'd0);
        check_eq("reset fill_tag", 64'(fill_tag), 64'd0);

        s = {4'd8, 16'h0, Root};

        // 4K walk, zero wait
        mem.delete();
        va = 39'h40_2030_1000;
        mem[pte_addr(Root, va, 2)]        = mk_pte(44'h80001, 8'h01);
        mem[pte_addr(44'h80001, va, 1)]   = mk_pte(44'h80002, 8'h01);
        mem[pte_addr(44'h80002, va, 0)]   = mk_pte(44'h12345, 8'hCF);
        run_walk(s, va, 1'b0, 0, "walk4k");
        check_eq("walk4k ppn_const", 64'(fill_ppn), 64'h12345);
        check_eq("walk4k level_const", 64'(fill_level), 64'd0);

        // 2M superpage
        mem.delete();
        va = {9'h003, 9'h005, 9'h1AB, 12'h234};
        mem[pte_addr(Root, va, 2)]      = mk_pte(44'h90000, 8'h01);
        mem[pte_addr(44'h90000, va, 1)] = mk_pte(44'h40000, 8'h4B);
        run_walk(s, va, 1'b0, 0, "walk2m");
        check_eq("walk2m ppn_const", 64'(fill_ppn), 64'h401AB);
        check_eq("walk2m level_const", 64'(fill_level), 64'd1);
        check_eq("walk2m reads_const", 64'(last_reads), 64'd2);

        // Misaligned 1G leaf
        mem.delete();
        mem[pte_addr(Root, va, 2)] = mk_pte(44'h1, 8'hCF);
        run_walk(s, va, 1'b0, 0, "mis1g");
        check_eq("mis1g reads_const", 64'(last_reads), 64'd1);

        // Invalid level-1 PTE
        mem.delete();
        mem[pte_addr(Root, va, 2)]      = mk_pte(44'h90000, 8'h01);
        mem[pte_addr(44'h90000, va, 1)] = mk_pte(44'h77777, 8'h00);
        run_walk(s, va, 1'b0, 0, "inval");
        check_eq("inval reads_const", 64'(last_reads), 64'd2);

        // Dirty bit clear: write faults, read fills
        mem.delete();
        va = 39'h12_3456_7000;
        mem[pte_addr(Root, va, 2)]      = mk_pte(44'h90000, 8'h01);
        mem[pte_addr(44'h90000, va, 1)] = mk_pte(44'h90001, 8'h01);
        mem[pte_addr(44'h90001, va, 0)] = mk_pte(44'h0ABCD, 8'h4F);
        run_walk(s, va, 1'b1, 0, "ad_write");
        run_walk(s, va, 1'b0, 0, "ad_read");

        // Bad MODE
        run_walk({4'd0, 16'h0, Root}, va, 1'b0, 0, "badmode");

        // Reset mid-walk during level-1 wait states
        @(negedge phi2);
        satp = s; walk_vaddr = va; walk_is_write = 1'b0; walk_req = 1'b1;
        @(negedge phi2);
        walk_req = 1'b0;
        check_eq("rstw l2 rq", 64'(mem_read_rq), 64'd1);
        mem_data = mem_rd(mem_addr); mem_ready = 1'b1;
        @(negedge phi2);
        mem_ready = 1'b0;
        @(negedge phi2);
        check_eq("rstw l1 rq", 64'(mem_read_rq), 64'd1);
        repeat (2) @(negedge phi2);
        rst = 1'b1;
        @(negedge phi2);
        rst = 1'b0;
        check_eq("rstw rq_drop", 64'({mem_read_rq, walk_busy}), 64'd0);
        mem_data = mem_rd(pte_addr(44'h90000, va, 1)); mem_ready = 1'b1;
        @(negedge phi2);
        mem_ready = 1'b0;
        check_eq("rstw stale_ready", 64'({walk_busy, walk_done, fill_valid, mem_read_rq}), 64'd0);
        run_walk(s, va, 1'b0, 0, "rstw fresh");

        // Random page tables with wait states
        for (int t = 0; t < 48; t++) begin
            mem.delete();
            a  = 44'({$urandom, $urandom});
            va = 39'({$urandom, $urandom});
            s  = {($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd8, 16'($urandom), a};
            for (int l = 2; l >= 0; l--) begin
                p = rand_pte(l);
                mem[pte_addr(a, va, l)] = p;
                if (p[0] && !p[1] && !p[3] && p[63:54] == 10'h0) a = p[53:10];
                else break;
            end
            run_walk(s, va, 1'($urandom), 3, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
